// File: rtl/aes_inv_round_core.sv
// Iterative AES-128 decryption core: initial AddRoundKey, nine inverse middle
// rounds and the inverse final round, one round per clock, keys fetched by index.
module aes_inv_round_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] ciphertext,
  output logic [3:0]   key_idx,
  input  logic [0:127] round_key,
  output logic         busy,
  output logic         done,
  output logic [0:127] plaintext
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  // Entry b of the inverse S-box lives at bits [8b : 8b+7].
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [0:127] state;
  logic [0:127] shifted, subbed, keyed, mixed;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant whose bit 3 is always set (09, 0b, 0d, 0e).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    // Row r rotates right by r: output column c takes input column (c - r) mod 4.
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        shifted[8*(r+4*c) +: 8] = state[8*(r+4*((c+4-r)%4)) +: 8];
    for (int unsigned n = 0; n < 16; n++)
      subbed[8*n +: 8] = inv_sbox(shifted[8*n +: 8]);
    keyed = subbed ^ round_key;
    for (int unsigned c = 0; c < 4; c++)
      mixed[32*c +: 32] = inv_mix_col(keyed[32*c +: 32]);
  end

  always_comb begin
    key_idx = 4'd10;
    case (fsm)
      ROUND:   key_idx = rnd;
      FINAL:   key_idx = 4'd0;
      default: key_idx = 4'd10;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      rnd       <= '0;
      state     <= '0;
      plaintext <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: if (start) begin
          state <= ciphertext ^ round_key;
          rnd   <= 4'd9;
          busy  <= 1'b1;
          fsm   <= ROUND;
        end
        ROUND: begin
          state <= mixed;
          if (rnd == 4'd1) fsm <= FINAL;
          else             rnd <= rnd - 4'd1;
        end
        FINAL: begin
          plaintext <= keyed;
          done      <= 1'b1;
          busy      <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_core.sv
// Bench for aes_inv_round_core: key store model, FIPS vectors, protocol corner
// cases, and random blocks produced by an independent forward-AES model.
module tb_aes_inv_round_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] ciphertext;
  logic [3:0]   key_idx;
  logic [0:127] round_key;
  logic         busy;
  logic         done;
  logic [0:127] plaintext;

  aes_inv_round_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ciphertext (ciphertext),
    .key_idx    (key_idx),
    .round_key  (round_key),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  always #5 clk = ~clk;

  localparam logic [0:127] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0]   sbox [256];
  logic [0:127] rk [0:10];
  logic [0:127] exp_q [$];
  logic [0:127] last_pt;
  int           checks = 0;
  int           failures = 0;
  int           done_cnt = 0;
  int           exp_dones = 0;

  always_comb round_key = (key_idx <= 4'd10) ? rk[key_idx] : '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pops one expected plaintext.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending block at %0t", $time);
      end else begin
        check("plaintext", plaintext, exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b, inv;
    for (int x = 0; x < 256; x++) begin
      b   = x[7:0];
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, b);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [0:127] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:127] aes_encrypt(input logic [0:127] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [0:127] o;
    for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ rk[0][8*n +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox[s[n]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q+4*c] = t[q+4*((c+q)%4)];
      if (r != 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[r][8*n +: 8];
    end
    for (int n = 0; n < 16; n++) o[8*n +: 8] = s[n];
    return o;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called #1 after an edge with the core idle. poke fires stray starts before E3 and E7.
  task automatic run_block(input logic [0:127] ct, input logic [0:127] exp,
                           input bit b2b, input bit poke);
    check("idle_key_idx", key_idx, 10);
    check("idle_busy", busy, 0);
    start      = 1'b1;
    ciphertext = ct;
    exp_q.push_back(exp);
    exp_dones++;
    @(posedge clk); #1;
    start      = 1'b0;
    ciphertext = rand128();
    for (int k = 1; k <= 10; k++) begin
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("key_idx", key_idx, 10 - k);
      check("plaintext_hold", plaintext, last_pt);
      if (poke && (k == 3 || k == 7)) begin
        start      = 1'b1;
        ciphertext = rand128();
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("key_idx_after", key_idx, 10);
    last_pt = exp;
    if (!b2b) begin
      @(posedge clk); #1;
      check("done_width", done, 0);
    end
  endtask

  task automatic abort_run(input logic [0:127] ct, input logic [0:127] exp);
    int d0;
    start      = 1'b1;
    ciphertext = ct;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_plaintext", plaintext, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_key_idx", key_idx, 10);
    exp_q.delete();
    last_pt = '0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_no_done", done_cnt, d0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:127] k, p;
    rst_n      = 1'b0;
    start      = 1'b0;
    ciphertext = '0;
    last_pt    = '0;
    build_sbox();
    repeat (3) @(posedge clk); #1;
    check("rst_plaintext", plaintext, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_key_idx", key_idx, 10);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_key(K_C1);
    run_block(CT_C1, PT_C1, 1'b0, 1'b0);
    load_key(K_B);
    run_block(CT_B, PT_B, 1'b0, 1'b0);
    run_block(CT_B, PT_B, 1'b0, 1'b1);

    load_key(K_C1);
    run_block(CT_C1, PT_C1, 1'b1, 1'b0);
    load_key(K_B);
    run_block(CT_B, PT_B, 1'b0, 1'b0);

    load_key(K_C1);
    abort_run(CT_C1, PT_C1);
    run_block(CT_C1, PT_C1, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      k = rand128();
      p = rand128();
      load_key(k);
      run_block(aes_encrypt(p), p, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk); #1;
    check("pending_blocks", exp_q.size(), 0);
    check("done_count", done_cnt, exp_dones);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_core.md
# aes_inv_round_core

Iterative AES-128 decryption engine: the inverse counterpart of the encryption middle-round datapath. It takes one 128-bit ciphertext block and executes the initial AddRoundKey, nine inverse middle rounds and the inverse final round, one round per clock. Round keys come from the external key store through an index/data lookup. The block sits between the UART receive framing and the plaintext UART transmit path of the decryption build.

## Interface
- No parameters. AES-128 only: Nr = 10, 11 round keys.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request. Sampled only in IDLE; ignored otherwise.
- ciphertext  input  [0:127]  block to decrypt. Sampled only on the accepted start edge.
- key_idx  output  [3:0]  round-key index requested this cycle, range 0..10.
- round_key  input  [0:127]  key-store word for key_idx. Must be combinationally valid in the same cycle as key_idx.
- busy  output  1  high while rounds are in progress.
- done  output  1  one-cycle pulse: plaintext has just been updated.
- plaintext  output  [0:127]  last result. Held until the next done.

## Operation
- State layout: bit 0 is the MSB. Byte n = bits [8n:8n+7]. The state is column-major: byte n is at row n%4, column n/4 (FIPS-197 ordering).
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - key_idx = 10.
  - On start: state <= ciphertext ^ round_key; rnd <= 9; go to ROUND.
- ROUND, key_idx = rnd:
  - Compute InvShiftRows, then InvSubBytes, then XOR round_key, then InvMixColumns. Register the result into state.
  - InvShiftRows: row r rotates right by r bytes.
  - InvMixColumns: column matrix rows {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial 0x11B.
  - If rnd == 1, go to FINAL. Otherwise rnd <= rnd − 1.
- FINAL, key_idx = 0:
  - Compute InvShiftRows, then InvSubBytes, then XOR round_key. There is no InvMixColumns.
  - Register the result into plaintext. Pulse done. Return to IDLE.
- The inverse S-box is a 256-entry byte lookup, 16 instances, combinational within the round cycle.
- state is internal. plaintext changes only on the FINAL edge.
- key_idx is a registered or decoded function of the FSM/rnd only. It never depends on inputs combinationally.

## Timing
- Reset (async assert, values immediate):
  - FSM = IDLE, rnd = 0, state = 0.
  - plaintext = 128'h0, done = 0, busy = 0, key_idx = 10.
- Edge E0: start accepted. busy = 1 after E0.
- Edges E1..E9: rounds 9..1. key_idx shows 9,8,…,1 during the cycles ending at E1..E9.
- Edge E10: final round. key_idx = 0 in the cycle before E10.
- After E10: done = 1 for exactly one cycle. busy = 0 and plaintext is valid.
- Latency is 10 clocks from the start edge to done high. Throughput is one block per 11 cycles.
- start while busy: ignored. No queueing, and ciphertext is not resampled.
- start in the cycle done is high: the FSM is in IDLE, so start is accepted. Back-to-back blocks give done every 11 cycles.
- start held high: a new block is accepted every IDLE cycle; the ciphertext seen at that edge is used.
- Reset mid-operation: the run is aborted with no done pulse, and all outputs take their reset values. The first start after rst_n release behaves normally.
- The key store must not change contents while busy. The block does not check this.

## Test plan
- Reset check: assert rst_n = 0 mid-run at E5, then release. Expect:
  - outputs immediately at reset values: plaintext 0, done 0, busy 0, key_idx 10;
  - no done pulse for the aborted block;
  - a fresh start decrypts correctly.
- FIPS-197 C.1 vector: key store expanded from 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Expect:
  - plaintext 00112233445566778899aabbccddeeff;
  - done exactly 10 clocks after the start edge;
  - key_idx sequence 10,9,…,0.
- FIPS-197 Appendix B vector: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32. Expect plaintext 3243f6a8885a308d313198a2e0370734.
- start pulses at E3 and E7 of a run, with a different ciphertext. Expect:
  - both pulses ignored;
  - the result matches the original ciphertext;
  - exactly one done pulse.
- Back-to-back: start asserted in the done cycle with the Appendix B block, following the C.1 block. Expect:
  - two done pulses 11 cycles apart;
  - both plaintexts correct;
  - the first plaintext held until the second done.
- Random regression: 1000 random key/ciphertext pairs checked against a reference AES-128 decrypt model. Expect a bit-exact plaintext on every pair.
